// File: rtl/tcon_pkg.sv
// +----------------------------------------------------------------+
// | tcon_pkg - shared defaults and types for the tcon hold stage     |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

package tcon_pkg;
   localparam int TCON_WIDTH   = 8;
   localparam int TCON_DEPTH   = 2;
   localparam int TCON_RST_VAL = 0;
   localparam int TCON_CNT_W   = 8;

   typedef logic [TCON_WIDTH-1:0] tcon_word_t;
endpackage

`default_nettype wire

// File: rtl/tcon_chg_fifo.sv
// +----------------------------------------------------------------+
// | tcon_chg_fifo - synchronous FIFO with registered head output    |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module tcon_chg_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       pop,
   output logic                       valid,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W-1:0] w_rptr_n;
   logic [OCC_W-1:0] r_count;
   logic [OCC_W-1:0] w_count_n;
   logic [WIDTH-1:0] r_dout;
   logic             w_pop;
   logic             w_push;

   assign valid    = (r_count != '0);
   assign full     = (r_count == OCC_W'(DEPTH));
   assign data_out = r_dout;
   assign count    = r_count;

   // A push on a full FIFO only succeeds if a pop frees a slot on the same edge.
   assign w_pop    = pop & valid;
   assign w_push   = push & (~full | w_pop);
   assign w_rptr_n = w_pop ? r_rptr + PTR_W'(1) : r_rptr;

   always_comb begin
      w_count_n = r_count;
      if (w_push && !w_pop) begin
         w_count_n = r_count + OCC_W'(1);
      end else if (!w_push && w_pop) begin
         w_count_n = r_count - OCC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_dout  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         r_rptr  <= w_rptr_n;
         r_count <= w_count_n;
         // Next head is either the entry being written this edge or one already stored.
         if (w_count_n != '0) begin
            r_dout <= (w_push && (r_wptr == w_rptr_n)) ? data_in : r_mem[w_rptr_n];
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/tcon_hold_reg.sv
// +----------------------------------------------------------------+
// | tcon_hold_reg - tcon load/hold state register with change stream |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module tcon_hold_reg
   import tcon_pkg::*;
#(
   parameter int               WIDTH   = TCON_WIDTH,
   parameter int               DEPTH   = TCON_DEPTH,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(TCON_RST_VAL),
   parameter int               CNT_W   = TCON_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] q,
   output logic             chg_valid,
   output logic [WIDTH-1:0] chg_data,
   input  logic             chg_ready,
   output logic             ovf,
   input  logic             ovf_clr,
   output logic [CNT_W-1:0] chg_cnt
);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_q;
   logic             r_ovf;
   logic [CNT_W-1:0] r_cnt;
   logic             w_chg;
   logic             w_pop;
   logic             w_full;
   logic             w_drop;
   logic             w_valid;
   logic [OCC_W-1:0] w_count;

   // Reloading the value already held is not a change.
   assign w_chg  = sel & (load_data != r_q);
   assign w_pop  = chg_ready & (w_count != '0);
   assign w_drop = w_chg & w_full & ~w_pop;

   tcon_chg_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_chg_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (w_chg),
      .data_in  (load_data),
      .pop      (chg_ready),
      .valid    (w_valid),
      .data_out (chg_data),
      .full     (w_full),
      .count    (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= RST_VAL;
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end else begin
         if (sel) begin
            r_q <= load_data;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_chg && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign q         = r_q;
   assign chg_valid = w_valid;
   assign ovf       = r_ovf;
   assign chg_cnt   = r_cnt;
endmodule

`default_nettype wire

// File: tb/tb_tcon_hold_reg.sv
// +----------------------------------------------------------------+
// | tb_tcon_hold_reg - scoreboard bench for tcon_hold_reg            |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module tb_tcon_hold_reg;
   import tcon_pkg::*;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst, sel, chg_ready, ovf_clr;
   tcon_word_t load_data;
   tcon_word_t q, chg_data, q2, chg_data2;
   logic       chg_valid, ovf, chg_valid2, ovf2;
   logic [7:0] chg_cnt;
   logic [1:0] chg_cnt2;

   tcon_hold_reg dut (
      .clk(clk), .rst(rst), .sel(sel), .load_data(load_data), .q(q),
      .chg_valid(chg_valid), .chg_data(chg_data), .chg_ready(chg_ready),
      .ovf(ovf), .ovf_clr(ovf_clr), .chg_cnt(chg_cnt)
   );

   tcon_hold_reg #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .sel(sel), .load_data(load_data), .q(q2),
      .chg_valid(chg_valid2), .chg_data(chg_data2), .chg_ready(chg_ready),
      .ovf(ovf2), .ovf_clr(ovf_clr), .chg_cnt(chg_cnt2)
   );

   always #5 clk = ~clk;

   // Reference model: held value, FIFO occupancy, sticky flag, total change count.
   tcon_word_t exp_q[$];
   tcon_word_t m_q;
   int         m_occ;
   bit         m_ovf;
   int         m_total;
   bit         checking = 1'b0;
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic s, input tcon_word_t d,
                        input logic rdy, input logic clr);
      bit pop_m, chg_m, drop_m;
      rst = r; sel = s; load_data = d; chg_ready = rdy; ovf_clr = clr;
      @(posedge clk);
      pop_m  = rdy && (m_occ > 0);
      chg_m  = s && (d != m_q);
      drop_m = 1'b0;
      if (r) begin
         m_q = '0; m_occ = 0; m_ovf = 1'b0; m_total = 0;
         exp_q.delete();
      end else begin
         if (chg_m) begin
            m_total++;
            if (m_occ < DEPTH || pop_m) begin
               exp_q.push_back(d);
               m_occ++;
            end else begin
               drop_m = 1'b1;
            end
         end
         if (pop_m) m_occ--;
         if (drop_m) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         if (s) m_q = d;
      end
      #2;
   endtask

   // Monitor: compares state every cycle and drains the scoreboard on each handshake.
   always @(negedge clk) begin
      if (checking) begin
         check("q", q, m_q);
         check("q_sat", q2, m_q);
         check("chg_valid", chg_valid, m_occ != 0);
         check("chg_valid_sat", chg_valid2, m_occ != 0);
         check("ovf", ovf, m_ovf);
         check("ovf_sat", ovf2, m_ovf);
         check("chg_cnt", chg_cnt, (m_total > 255) ? 255 : m_total);
         check("chg_cnt_sat", chg_cnt2, (m_total > 3) ? 3 : m_total);
         if (chg_valid && chg_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL chg_pop: got %0h with nothing expected at %0t", chg_data, $time);
            end else begin
               tcon_word_t e;
               e = exp_q.pop_front();
               check("chg_data", chg_data, e);
               check("chg_data_sat", chg_data2, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset dominates a load of FF, then FF appears one cycle after release.
      apply(1, 1, 8'hFF, 0, 0);
      checking = 1'b1;
      apply(1, 1, 8'hFF, 0, 0);
      check("rst_chg_data", chg_data, 0);
      apply(0, 1, 8'hFF, 0, 0);
      apply(0, 0, 8'h00, 1, 0);
      // Hold ignores load_data; reload of the same value is silent.
      apply(0, 1, 8'h3C, 1, 0);
      repeat (5) apply(0, 0, 8'hA5, 0, 0);
      apply(0, 1, 8'h3C, 0, 0);
      apply(0, 0, 8'h00, 1, 0);
      // Ordering with a stalled consumer.
      apply(0, 1, 8'h11, 0, 0);
      apply(0, 1, 8'h22, 0, 0);
      apply(0, 0, 8'h00, 1, 0);
      apply(0, 0, 8'h00, 1, 0);
      apply(0, 0, 8'h00, 1, 0);
      // Overflow, set-wins against clear, then clear alone.
      apply(0, 1, 8'h11, 0, 0);
      apply(0, 1, 8'h22, 0, 0);
      apply(0, 1, 8'h33, 0, 0);
      apply(0, 1, 8'h44, 0, 1);
      apply(0, 0, 8'h00, 0, 1);
      // Push and pop together on a full FIFO.
      apply(0, 1, 8'h55, 1, 0);
      apply(0, 0, 8'h00, 1, 0);
      apply(0, 0, 8'h00, 1, 0);
      // Mid-sequence reset with pending data.
      apply(0, 1, 8'h66, 0, 0);
      apply(1, 1, 8'h77, 1, 0);
      apply(0, 0, 8'h00, 0, 0);
      // Randomized traffic over a small value alphabet to provoke reloads.
      for (int i = 0; i < 3000; i++) begin
         logic       r, s, rdy, clr;
         tcon_word_t d;
         r   = ($urandom_range(0, 149) == 0);
         s   = ($urandom_range(0, 3) != 0);
         d   = ($urandom_range(0, 3) == 0) ? tcon_word_t'($urandom) : tcon_word_t'($urandom_range(0, 4));
         rdy = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 7) == 0);
         apply(r, s, d, rdy, clr);
      end
      repeat (4) apply(0, 0, 8'h00, 1, 0);
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
